t7447_decode: RTL

Two-digit seven-segment to BCD decoder: inverse of the display path, recovering the BCD digits driven onto a 14-bit active-low 7447-style segment bus. Sits on the check side of the display chain: it watches a seg[14:1] bus, waits for the pattern to settle, and reports the two decoded digits with one-cycle strobes. Used by the readback and self-check logic that confirms what the display is really showing.

---
 rtl/t7447_decode.sv | 94 +++++++++
 1 files changed

// File: rtl/t7447_decode.sv
// Two-digit active-low seven-segment to BCD decoder with settle filter.
// Optional macro T7447_TAIL_EN: also accept the tailed 6 (acdefg) and 9 (abcdfg) glyphs.
module t7447_decode #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [14:1] seg,
   output logic [7:0]  bcd,
   output logic [1:0]  blank,
   output logic        valid,
   output logic        err
);

   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

   state_t        state;
   logic [14:1]   held;
   logic [CW-1:0] cnt;

   // Returns {illegal, value}; pattern bit 0 is segment a, bit 6 is g, 0 = lit.
   function automatic logic [4:0] dec(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'b1000000: r = 5'h00;
         7'b1111001: r = 5'h01;
         7'b0100100: r = 5'h02;
         7'b0110000: r = 5'h03;
         7'b0011001: r = 5'h04;
         7'b0010010: r = 5'h05;
         7'b0000011: r = 5'h06;
         7'b1111000: r = 5'h07;
         7'b0000000: r = 5'h08;
         7'b0011000: r = 5'h09;
         7'b1111111: r = 5'h0F;
`ifdef T7447_TAIL_EN
         7'b0000010: r = 5'h06;
         7'b0010000: r = 5'h09;
`endif
         default:    r = 5'h1F;
      endcase
      return r;
   endfunction

   logic [4:0] dec_hi, dec_lo;

   always_comb begin
      dec_hi = dec(held[14:8]);
      dec_lo = dec(held[7:1]);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bcd   <= 8'h00;
         blank <= 2'b00;
         valid <= 1'b0;
         err   <= 1'b0;
         held  <= '1;
         cnt   <= '0;
         state <= IDLE;
      end else begin
         valid <= 1'b0;
         err   <= 1'b0;
         if (seg != held) begin
            held  <= seg;
            cnt   <= '0;
            state <= SETTLE;
         end else begin
            case (state)
               // IDLE behaves as SETTLE on the all-ones pattern loaded at reset.
               IDLE, SETTLE: begin
                  if (cnt == LAST) begin
                     state <= LOCKED;
                     if (dec_hi[4] || dec_lo[4]) begin
                        err <= 1'b1;
                     end else begin
                        bcd   <= {dec_hi[3:0], dec_lo[3:0]};
                        blank <= {held[14:8] == 7'h7F, held[7:1] == 7'h7F};
                        valid <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
